uart_tx_engine: RTL and testbench

UART transmit serializer, the reader side of the TX uart_fifo. It pops words from the FIFO using the FIFO's one-cycle read latency, checks the FIFO word parity flag and frames each byte (start, LSB-first data, optional parity, 1 or 2 stop bits). It drives the TXD line at a runtime-programmable bit period. It sits between the TX uart_fifo and the pad, under the UART register block.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx_engine.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX engine and the RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_STOP_BITS_MAX = 2;

  // Callers zero-extend their data word; the extra zero bits do not change the XOR.
  localparam int UART_PARITY_MAX_DW = 32;

  function automatic logic uart_parity(input logic [UART_PARITY_MAX_DW-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that marks the last cycle of each bit period.
// The divisor is captured on i_start and reused for every following bit.
module uart_bit_timer #(
  parameter int BDW = 16
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  logic           i_start,
  input  logic           i_en,
  input  logic [BDW-1:0] i_div,
  output logic           o_bit_end
);

  logic [BDW-1:0] cnt;
  logic [BDW-1:0] div_q;

  assign o_bit_end = i_en && (cnt == '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (i_start) begin
      cnt   <= i_div;
      div_q <= i_div;
    end else if (i_en) begin
      cnt <= (cnt == '0) ? div_q : cnt - BDW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops words from the TX FIFO and frames them
// onto TXD with start, LSB-first data, optional parity and 1 or 2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DW  = 8,
  parameter int BDW = 16
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  logic           i_tx_en,
  input  logic [BDW-1:0] i_baud_div,
  input  logic           i_parity_en,
  input  logic           i_parity_odd,
  input  logic           i_stop2,
  input  logic           i_fifo_empty,
  input  logic [DW-1:0]  i_fifo_data,
  input  logic           i_fifo_valid,
  input  logic           i_fifo_parity_error,
  output logic           o_fifo_rd_req,
  output logic           o_txd,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_fifo_err,
  output uart_tx_state_t o_state
);

  localparam int CW = $clog2(DW + 1);
  localparam int SW = $clog2(UART_STOP_BITS_MAX);

  // Handshake: o_fifo_rd_req is a single-cycle request issued only after
  // i_fifo_empty=0 was seen in IDLE; the FIFO answers one cycle later with
  // i_fifo_valid, which is sampled exactly once, in FETCH.

  uart_tx_state_t                 state;
  logic [DW-1:0]                  shreg;
  logic [CW-1:0]                  bit_cnt;
  logic [SW-1:0]                  stop_cnt;
  logic                           par_en_q;
  logic                           par_bit_q;
  logic                           stop2_q;
  logic                           txd_q;
  logic                           rd_req_q;
  logic                           done_q;
  logic                           err_q;
  logic                           timer_start;
  logic                           timer_en;
  logic                           bit_end;
  logic [UART_PARITY_MAX_DW-1:0]  par_word;

  assign timer_start = (state == FETCH) && i_fifo_valid && !i_fifo_parity_error;
  assign timer_en    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign par_word    = UART_PARITY_MAX_DW'(i_fifo_data);

  uart_bit_timer #(
    .BDW(BDW)
  ) u_bit_timer (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_start  (timer_start),
    .i_en     (timer_en),
    .i_div    (i_baud_div),
    .o_bit_end(bit_end)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      txd_q     <= 1'b1;
      rd_req_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_tx_en && !i_fifo_empty) begin
            rd_req_q <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: state <= FETCH;
        FETCH: begin
          if (i_fifo_valid && i_fifo_parity_error) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (i_fifo_valid) begin
            // Parity is computed from the whole word here so the data bits can be shifted out.
            shreg     <= i_fifo_data;
            par_en_q  <= i_parity_en;
            par_bit_q <= uart_parity(par_word, i_parity_odd);
            stop2_q   <= i_stop2;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            txd_q     <= 1'b0;
            state     <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            txd_q <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == CW'(DW - 1)) begin
              if (par_en_q) begin
                txd_q <= par_bit_q;
                state <= PARITY;
              end else begin
                txd_q <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd_q   <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            txd_q <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && (stop_cnt != SW'(UART_STOP_BITS_MAX - 1))) begin
              stop_cnt <= stop_cnt + SW'(1);
            end else begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_fifo_rd_req = rd_req_q;
  assign o_txd         = txd_q;
  assign o_busy        = (state != IDLE);
  assign o_done        = done_q;
  assign o_fifo_err    = err_q;
  assign o_state       = state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: FIFO model, line-level frame
// reference model and a scoreboard of expected frames.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int BDW = 16;
  localparam int W   = 32;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            tx_en = 1'b0;
  logic [BDW-1:0]  baud_div = '0;
  logic            parity_en = 1'b0;
  logic            parity_odd = 1'b0;
  logic            stop2 = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DW-1:0]   fifo_data = '0;
  logic            fifo_valid = 1'b0;
  logic            fifo_perr = 1'b0;
  logic            rd_req, txd, busy, done, fifo_err;
  uart_tx_state_t  dbg_state;

  always #5 clk = ~clk;

  uart_tx_engine #(.DW(DW), .BDW(BDW)) dut (
    .i_clk              (clk),
    .i_nrst             (nrst),
    .i_tx_en            (tx_en),
    .i_baud_div         (baud_div),
    .i_parity_en        (parity_en),
    .i_parity_odd       (parity_odd),
    .i_stop2            (stop2),
    .i_fifo_empty       (fifo_empty),
    .i_fifo_data        (fifo_data),
    .i_fifo_valid       (fifo_valid),
    .i_fifo_parity_error(fifo_perr),
    .o_fifo_rd_req      (rd_req),
    .o_txd              (txd),
    .o_busy             (busy),
    .o_done             (done),
    .o_fifo_err         (fifo_err),
    .o_state            (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];      // {div, stop2, odd, parity_en, data}
  logic [DW:0]   fifo_q[$];     // {parity_error, data}
  logic          force_ne = 1'b0;
  logic          pending = 1'b0;
  logic [DW:0]   pend_word = '0;
  int            cyc = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, rd_viol = 0;
  int            gap_last = -1, end_cyc = 0;
  logic          in_frame = 1'b0, rogue = 1'b0, prev_rd = 1'b0, empty_at_edge = 1'b1;
  int            pos = 0, flen = 0, bdiv = 0, bad_pos = -1;
  logic [2:0]    bad_act = '0;
  logic          bad_exp = 1'b0;
  logic [W-1:0]  cur = '0;
  logic          bits [0:11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [7:0] d, input logic pe, input logic odd,
                                        input logic s2, input logic [15:0] div);
    return {5'd0, div, s2, odd, pe, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int div, input logic pe, input logic odd, input logic s2);
    baud_div   = BDW'(div);
    parity_en  = pe;
    parity_odd = odd;
    stop2      = s2;
  endtask

  task automatic push(input logic [7:0] d, input logic perr, input logic with_exp);
    fifo_q.push_back({perr, d});
    if (with_exp && !perr) exp_q.push_back(pack(d, parity_en, parity_odd, stop2, baud_div));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 && !in_frame &&
                           !pending && busy === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_txd_low(input string name);
    int n = 0;
    while (txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 400), 1);
  endtask

  // ---------------- FIFO model: one-cycle read latency ----------------
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      fifo_valid = 1'b0;
      fifo_perr  = 1'b0;
      if (nrst !== 1'b1) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          fifo_valid = 1'b1;
          fifo_data  = pend_word[DW-1:0];
          fifo_perr  = pend_word[DW];
          pending    = 1'b0;
        end
        if (rd_req === 1'b1 && fifo_q.size() > 0) begin
          pend_word = fifo_q.pop_front();
          pending   = 1'b1;
        end
      end
      fifo_empty = !(fifo_q.size() > 0 || force_ne);
    end
  end

  always @(posedge clk) empty_at_edge <= fifo_empty;

  // ---------------- monitor: per-cycle line check against the frame model ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (nrst !== 1'b1) begin
        in_frame = 1'b0;
        rogue    = 1'b0;
        prev_rd  = 1'b0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (fifo_err === 1'b1) err_cnt++;
        if (rd_req === 1'b1) begin
          rd_cnt++;
          if (prev_rd || empty_at_edge) rd_viol++;
        end
        prev_rd = rd_req;
        if (rogue && busy === 1'b0) rogue = 1'b0;
        if (in_frame && pos == flen) begin
          checks++;
          if (bad_pos >= 0) begin
            errors++;
            $display("FAIL frame_line data=%02h cycle %0d of %0d: txd,busy,done actual=%b required=%b10",
                     cur[7:0], bad_pos, flen, bad_act, bad_exp);
          end
          check("done_pulse", 32'(done), 1);
          in_frame = 1'b0;
          end_cyc  = cyc - 1;
        end
        if (!in_frame && !rogue && txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start actual=start_bit required=idle_line cycle=%0d", cyc);
            rogue = 1'b1;
          end else begin
            int n;
            cur  = exp_q.pop_front();
            bdiv = int'(cur[26:11]);
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = cur[i];
            n = 9;
            if (cur[8]) begin
              bits[n] = logic'($countones(cur[7:0]) % 2) ^ cur[9];
              n++;
            end
            bits[n] = 1'b1;
            n++;
            if (cur[10]) begin
              bits[n] = 1'b1;
              n++;
            end
            flen     = n * (bdiv + 1);
            gap_last = cyc - end_cyc - 1;
            pos      = 0;
            bad_pos  = -1;
            in_frame = 1'b1;
          end
        end
        if (in_frame) begin
          if ((txd !== bits[pos / (bdiv + 1)] || busy !== 1'b1 || done !== 1'b0) && bad_pos < 0) begin
            bad_pos = pos;
            bad_act = {txd, busy, done};
            bad_exp = bits[pos / (bdiv + 1)];
          end
          pos++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int d0, e0, r0, low_cnt, n, nerr, nok;
    logic [7:0] d;
    logic pe;

    repeat (2) @(negedge clk);
    check("reset_txd", 32'(txd), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(fifo_err), 0);
    check("reset_rd_req", 32'(rd_req), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    #1 nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 at div=3 with 0xA5: one read request, one done
    set_cfg(3, 0, 0, 0);
    tx_en = 1'b1;
    d0 = done_cnt; r0 = rd_cnt;
    push(8'hA5, 0, 1);
    wait_idle(500);
    check("a5_rd_req_count", 32'(rd_cnt - r0), 1);
    check("a5_done_count", 32'(done_cnt - d0), 1);

    // parity and stop-bit variants
    set_cfg(3, 1, 0, 0); push(8'h01, 0, 1); wait_idle(500);
    set_cfg(3, 1, 1, 0); push(8'h01, 0, 1); wait_idle(500);
    set_cfg(3, 1, 1, 0); push(8'hFF, 0, 1); wait_idle(500);
    set_cfg(3, 0, 0, 1); push(8'h96, 0, 1); wait_idle(500);

    // dropped word followed by a good one
    set_cfg(2, 0, 0, 0);
    d0 = done_cnt; e0 = err_cnt;
    push(8'h3C, 1, 1);
    push(8'h55, 0, 1);
    wait_idle(500);
    check("perr_err_pulses", 32'(err_cnt - e0), 1);
    check("perr_done_pulses", 32'(done_cnt - d0), 1);

    // back-to-back words at div=0: gap of three mark cycles
    set_cfg(0, 0, 0, 0);
    push(8'h00, 0, 1);
    push(8'hFF, 0, 1);
    wait_idle(500);
    check("b2b_gap", 32'(gap_last), 3);

    // FIFO claims non-empty but never returns data
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; low_cnt = 0;
    force_ne = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    force_ne = 1'b0;
    repeat (6) @(negedge clk);
    check("uflow_txd_low_cycles", 32'(low_cnt), 0);
    check("uflow_done", 32'(done_cnt - d0), 0);
    check("uflow_err", 32'(err_cnt - e0), 0);
    check("uflow_requested", 32'(rd_cnt - r0 > 0), 1);
    check("uflow_idle", 32'(busy), 0);

    // randomized batches, config fixed within a batch
    for (int b = 0; b < 10; b++) begin
      set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      n = $urandom_range(1, 6);
      nerr = 0; nok = 0;
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < n; i++) begin
        d  = 8'($urandom_range(0, 255));
        pe = ($urandom_range(0, 6) == 0);
        if (pe) nerr++; else nok++;
        push(d, pe, 1);
      end
      wait_idle(3000);
      check("rand_done_count", 32'(done_cnt - d0), 32'(nok));
      check("rand_err_count", 32'(err_cnt - e0), 32'(nerr));
    end

    // i_tx_en dropped mid-frame: frame completes, no further request
    set_cfg(1, 0, 0, 0);
    d0 = done_cnt; r0 = rd_cnt;
    push(8'h5A, 0, 1);
    push(8'h81, 0, 0);
    wait_txd_low("txen_start_seen");
    repeat (3) @(negedge clk);
    tx_en = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("txen_frame_done", 32'(done_cnt - d0), 1);
    check("txen_one_request", 32'(rd_cnt - r0), 1);
    check("txen_word_left", 32'(fifo_q.size()), 1);
    fifo_q.delete();
    repeat (2) @(negedge clk);

    // reset asserted during data bit 4 of 0xC3 (line low there)
    set_cfg(3, 0, 0, 0);
    tx_en = 1'b1;
    push(8'hC3, 0, 1);
    wait_txd_low("rst_start_seen");
    repeat (21) @(negedge clk);
    d0 = done_cnt;
    check("rst_pre_txd", 32'(txd), 0);
    #2 nrst = 1'b0;
    tx_en = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 1);
    check("rst_async_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    r0 = rd_cnt;
    push(8'h77, 0, 0);
    repeat (20) @(negedge clk);
    check("rst_no_rd_req", 32'(rd_cnt - r0), 0);
    check("rst_no_done", 32'(done_cnt - d0), 0);
    check("rst_idle", 32'(busy), 0);
    fifo_q.delete();

    check("rd_req_rules", 32'(rd_viol), 0);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
